// File: rtl/priority_enc_4to2_reg.sv
// -----------------------------------------------------------------------------
// priority_enc_4to2_reg
//
// Registered priority encoder. Reduces a request vector to the binary index of
// its highest-numbered set bit, plus an "any request" flag and a one-hot mask
// of the winner. Results appear one clock after the vector is sampled; a new
// vector is accepted every cycle.
//
// Parameters:
//   WIDTH  - number of request inputs (power of two, >= 2). Default 4.
//   OUT_W  - width of the encoded index, derived as $clog2(WIDTH). Do not
//            override.
//
// Ports:
//   clk     in   1       rising-edge clock
//   rst     in   1       synchronous, active-high reset
//   in      in   WIDTH   request vector, bit WIDTH-1 has highest priority
//   out     out  OUT_W   index of the highest set bit (0 when none set)
//   valid   out  1       at least one request bit was set
//   onehot  out  WIDTH   one-hot mask of the winning bit, 0 when !valid
//
// Unknown (X/Z) bits on `in` propagate as all-X results in simulation rather
// than resolving to a default index; synthesis treats that path as don't-care.
// -----------------------------------------------------------------------------
module priority_enc_4to2_reg #(
    parameter int WIDTH = 4,
    parameter int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    logic [OUT_W-1:0] out_d,    out_q;
    logic             valid_d,  valid_q;
    logic [WIDTH-1:0] onehot_d, onehot_q;

    // Combinational encode: scan from MSB down, the first set bit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, so no path leaves a value held and no latch is inferred.
        out_d    = '0;
        valid_d  = 1'b0;
        onehot_d = '0;

        if ($isunknown(in)) begin
            // Refuse to guess an index from an unknown request vector.
            out_d    = 'x;
            valid_d  = 1'bx;
            onehot_d = 'x;
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in[i] && !valid_d) begin
                    out_d   = OUT_W'(i);
                    valid_d = 1'b1;
                end
            end
            if (valid_d) begin
                onehot_d = WIDTH'(1) << out_d;
            end
        end
    end

    // Output registers; reset wins over everything, including unknown inputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples its pre-edge inputs, independent of statement order.
        if (rst) begin
            out_q    <= '0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
        end else begin
            out_q    <= out_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
        end
    end

    assign out    = out_q;
    assign valid  = valid_q;
    assign onehot = onehot_q;

endmodule

// File: tb/tb_priority_enc_4to2_reg.sv
// -----------------------------------------------------------------------------
// tb_priority_enc_4to2_reg
//
// Bench for priority_enc_4to2_reg (default 4->2 configuration). A reference
// model samples the same inputs as the DUT at each rising edge and computes the
// expected outputs arithmetically (highest set bit via log2, valid via a
// non-zero test). A compare process checks the DUT against it on every falling
// edge once reset has been seen. Directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_priority_enc_4to2_reg;

    localparam int W  = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_s;
    logic [OW-1:0] out_s;
    logic          valid_s;
    logic [W-1:0]  onehot_s;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    logic [OW-1:0] exp_out;
    logic          exp_valid;
    logic [W-1:0]  exp_onehot;
    bit            armed = 1'b0;
    bit            four_state;

    priority_enc_4to2_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_s),
        .out    (out_s),
        .valid  (valid_s),
        .onehot (onehot_s)
    );

    always #5 clk = ~clk;

    // Index of the highest set bit of a non-zero vector: floor(log2(v)).
    function automatic int hi_bit(input logic [W-1:0] v);
        return $clog2(int'(v) + 1) - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be after this edge.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp_out    = '0;
            exp_valid  = 1'b0;
            exp_onehot = '0;
            armed      = 1'b1;
        end else if ($isunknown(in_s)) begin
            exp_out    = 'x;
            exp_valid  = 1'bx;
            exp_onehot = 'x;
        end else if (in_s == '0) begin
            exp_out    = '0;
            exp_valid  = 1'b0;
            exp_onehot = '0;
        end else begin
            exp_out    = OW'(hi_bit(in_s));
            exp_valid  = 1'b1;
            exp_onehot = W'(1) << hi_bit(in_s);
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            check("model out",    32'(out_s),    32'(exp_out));
            check("model valid",  32'(valid_s),  32'(exp_valid));
            check("model onehot", 32'(onehot_s), 32'(exp_onehot));
        end
    end

    // Apply one input vector/reset value for one clock; returns at the next
    // falling edge, when the result for this vector is on the outputs.
    task automatic drive(input logic [W-1:0] v, input logic r);
        in_s = v;
        rst  = r;
        @(negedge clk);
    endtask

    task automatic expect_lit(input string tag, input logic [OW-1:0] o,
                              input logic vl, input logic [W-1:0] oh);
        check({tag, " out"},    32'(out_s),    32'(o));
        check({tag, " valid"},  32'(valid_s),  32'(vl));
        check({tag, " onehot"}, 32'(onehot_s), 32'(oh));
    endtask

    initial begin
        logic [W-1:0] probe;
        logic [W-1:0] single [4];
        logic [OW-1:0] single_idx [4];

        probe      = 'x;
        four_state = $isunknown(probe);
        rst        = 1'b1;
        in_s       = 4'b1111;

        // Reset with all requests set, then with unknown inputs.
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b1);
        expect_lit("reset in=1111", 2'b00, 1'b0, 4'b0000);
        drive('x, 1'b1);
        drive('x, 1'b1);
        expect_lit("reset in=xxxx", 2'b00, 1'b0, 4'b0000);

        // Single bits, back to back.
        single     = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        single_idx = '{2'b11, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            drive(single[i], 1'b0);
            expect_lit("single", single_idx[i], 1'b1, single[i]);
        end

        // Empty and priority.
        drive(4'b0000, 1'b0);
        expect_lit("empty", 2'b00, 1'b0, 4'b0000);
        drive(4'b1100, 1'b0);
        expect_lit("prio 1100", 2'b11, 1'b1, 4'b1000);
        drive(4'b0111, 1'b0);
        expect_lit("prio 0111", 2'b10, 1'b1, 4'b0100);

        // Exhaustive sweep, checked by the compare process.
        for (int v = 0; v < 16; v++) begin
            drive(W'(v), 1'b0);
        end

        // X propagation and recovery.
        drive('x, 1'b0);
        if (four_state) begin
            expect_lit("xprop", 2'bxx, 1'bx, 4'bxxxx);
        end
        drive(4'b0011, 1'b0);
        expect_lit("x recover", 2'b01, 1'b1, 4'b0010);

        // Mid-stream reset discards the in-flight result.
        drive(4'b1000, 1'b0);
        expect_lit("pre-reset", 2'b11, 1'b1, 4'b1000);
        drive(4'b0001, 1'b1);
        expect_lit("mid reset", 2'b00, 1'b0, 4'b0000);
        drive(4'b0100, 1'b0);
        expect_lit("post reset", 2'b10, 1'b1, 4'b0100);

        // Randomized stream with occasional resets.
        for (int n = 0; n < 300; n++) begin
            drive(W'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
